tetris_move_ctrl: RTL and testbench
===================================

# tetris_move_ctrl

Move-request controller that sits directly upstream of the piece-position register (`block_pos`) in the Tetris datapath. It synchronizes the raw left/right/down buttons and runs the gravity timer. It checks each request against the board-collision flags and emits mutually exclusive one-cycle `drop`/`left`/`right` pulses. When a downward move is blocked, it emits `lock` instead and waits for the next piece to spawn.

## Interface
- `GRAVITY_TICKS`, default 25_000_000: clock cycles per gravity step (≥4).
- `REPEAT_DELAY`, default 6_250_000: hold cycles before auto-repeat starts.
- `REPEAT_RATE`, default 2_500_000: cycles between auto-repeat requests.
- `clk` in 1: system clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `run` in 1: game active level; low = pause.
- `spawn` in 1: one-cycle pulse when a new piece has been placed at its start position.
- `btn_left`, `btn_right`, `btn_down` in 1 each: raw asynchronous buttons, active-high.
- `blk_left`, `blk_right`, `blk_down` in 1 each: collision flags for the current position (1 = move illegal).
- `drop`, `left`, `right` out 1 each: registered one-cycle move pulses to `block_pos`.
- `lock` out 1: registered one-cycle pulse; the piece must be merged into the board.

## Operation
- Each button passes through a 2-flop synchronizer, then a rising-edge detector; an edge sets that button's pending flag.
- Gravity counter, width `$clog2(GRAVITY_TICKS)`:
  - Counts in RUN and SETTLE.
  - At `GRAVITY_TICKS-1` it wraps to 0 and sets `grav_pend`.
  - A down edge also clears the counter.
- FSM states and transitions:
  - IDLE: entered from reset or whenever `run`=0. No outputs. All pending flags cleared; gravity counter held. `run`=1 → RUN.
  - RUN: at most one action per cycle, priority drop > left > right.
  - Drop request (`grav_pend` or down pending): if `blk_down`=0, pulse `drop`, clear both flags, go to SETTLE. If `blk_down`=1, pulse `lock`, clear all pending, go to LOCKED.
  - Left request: if `blk_left`=0, pulse `left`, go to SETTLE. If `blk_left`=1, discard silently and stay in RUN. Right is the mirror of left.
  - Left and right edges in the same cycle cancel: both flags are cleared and nothing is emitted.
  - SETTLE: exactly one cycle with no outputs, so `block_pos` and the collision logic can update. Pending flags may still set. → RUN.
  - LOCKED: no outputs, gravity counter held at 0, button edges ignored. `spawn` → RUN.
- `run` falling in any state → IDLE on the next edge; this overrides LOCKED and SETTLE. An in-flight output pulse still completes its single cycle.

## Timing
- Reset values: `drop`=`left`=`right`=`lock`=0, state IDLE, counters 0, synchronizer flops 0.
- Outputs are registered and never high for more than one cycle; at most one of the four outputs is high per cycle.
- Button latency: a button first sampled high at edge k sets its pending flag at edge k+2. The pulse is visible after edge k+3 when the FSM is in RUN.
- Minimum spacing between any two pulses is 2 cycles (pulse, then SETTLE).
- Collision flags are sampled only in RUN, in the cycle the decision is made.

## Configuration
- `TETRIS_AUTOREPEAT_EN` defined:
  - A left or right button held continuously re-sets its pending flag after `REPEAT_DELAY` cycles, then every `REPEAT_RATE` cycles.
  - Release, or the opposite button, resets its repeat counter.
- Not defined: edge-only behaviour. The repeat parameters are accepted but unused, and no repeat counters are synthesized.

## Structure
- Shared package `tetris_pkg`: FSM state enum (IDLE, RUN, SETTLE, LOCKED) and the move-request encoding, reused by the board/collision blocks.
- Sub-module `btn_sync`: 2-flop synchronizer plus rising-edge detector, also exposing the synchronized level for auto-repeat. Instantiated three times.

## Test plan
- Reset released, `run`=1, `GRAVITY_TICKS`=8, no buttons → `drop` pulses every 8 cycles; `left`/`right`/`lock` stay 0.
- `btn_left` high for 20 cycles, `blk_left`=0 → exactly one `left` pulse, 3 cycles after the first sampling edge; with `TETRIS_AUTOREPEAT_EN`, `REPEAT_DELAY`=10 and `REPEAT_RATE`=4, further pulses follow.
- Gravity tick with `blk_down`=1 → one `lock` pulse, then no outputs until `spawn`; a button press during LOCKED produces nothing.
- Down edge and left edge in the same cycle → `drop` in cycle t, no output in t+1 (SETTLE), `left` in t+2.
- Left and right edges in the same cycle → no pulse at all; `btn_right` with `blk_right`=1 → no pulse, FSM stays in RUN.
- `run` dropped mid-SETTLE, then restored → IDLE with pending flags cleared; the gravity counter resumes from its held value.

Source files
------------

// File: rtl/tetris_pkg.sv
// Shared types for the Tetris datapath: move-controller FSM states and the
// move-request encoding also used by the board and collision blocks.
package tetris_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_SETTLE = 2'd2,
        ST_LOCKED = 2'd3
    } move_state_e;

    typedef enum logic [2:0] {
        MV_NONE  = 3'd0,
        MV_DROP  = 3'd1,
        MV_LEFT  = 3'd2,
        MV_RIGHT = 3'd3,
        MV_LOCK  = 3'd4
    } move_req_e;

    // Counter width able to hold values 0..n-1, never narrower than one bit.
    function automatic int cnt_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/btn_sync.sv
// Two-flop synchronizer for one raw push button, followed by a rising-edge
// detector. The synchronized level is exposed for auto-repeat timing.
module btn_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_i,
    output logic level_o,
    output logic rise_o
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            meta_q <= btn_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign level_o = sync_q;
    assign rise_o  = sync_q & ~prev_q;

endmodule

// File: rtl/tetris_move_ctrl.sv
// Move-request controller feeding block_pos: button sync, gravity timer and
// collision-checked drop/left/right/lock pulses. Optional TETRIS_AUTOREPEAT_EN.
module tetris_move_ctrl
    import tetris_pkg::*;
#(
    parameter int GRAVITY_TICKS = 25_000_000,
    parameter int REPEAT_DELAY  = 6_250_000,
    parameter int REPEAT_RATE   = 2_500_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    input  logic spawn,
    input  logic btn_left,
    input  logic btn_right,
    input  logic btn_down,
    input  logic blk_left,
    input  logic blk_right,
    input  logic blk_down,
    output logic drop,
    output logic left,
    output logic right,
    output logic lock
);

    localparam int GW = $clog2(GRAVITY_TICKS);

    if (GRAVITY_TICKS < 4 || REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_bad_params
        $error("tetris_move_ctrl: GRAVITY_TICKS must be >= 4 and repeat timings >= 1");
    end

    logic lvl_l, lvl_r, lvl_d;
    logic rise_l, rise_r, rise_d;

    btn_sync u_sync_left (
        .clk     (clk),
        .rst_n   (rst_n),
        .btn_i   (btn_left),
        .level_o (lvl_l),
        .rise_o  (rise_l)
    );

    btn_sync u_sync_right (
        .clk     (clk),
        .rst_n   (rst_n),
        .btn_i   (btn_right),
        .level_o (lvl_r),
        .rise_o  (rise_r)
    );

    btn_sync u_sync_down (
        .clk     (clk),
        .rst_n   (rst_n),
        .btn_i   (btn_down),
        .level_o (lvl_d),
        .rise_o  (rise_d)
    );

    logic rep_l_fire;
    logic rep_r_fire;
    logic unused_lvl;

`ifdef TETRIS_AUTOREPEAT_EN
    localparam int RW = cnt_width(REPEAT_DELAY > REPEAT_RATE ? REPEAT_DELAY : REPEAT_RATE);

    logic [RW-1:0] rep_l_cnt_q, rep_l_cnt_d;
    logic [RW-1:0] rep_r_cnt_q, rep_r_cnt_d;
    logic          rep_l_arm_q, rep_l_arm_d;
    logic          rep_r_arm_q, rep_r_arm_d;

    // A held button fires first after REPEAT_DELAY cycles, then every REPEAT_RATE.
    always_comb begin
        rep_l_cnt_d = rep_l_cnt_q;
        rep_l_arm_d = rep_l_arm_q;
        rep_l_fire  = 1'b0;
        if (!lvl_l || lvl_r) begin
            rep_l_cnt_d = '0;
            rep_l_arm_d = 1'b0;
        end else if (rep_l_cnt_q == (rep_l_arm_q ? RW'(REPEAT_RATE - 1) : RW'(REPEAT_DELAY - 1))) begin
            rep_l_fire  = 1'b1;
            rep_l_cnt_d = '0;
            rep_l_arm_d = 1'b1;
        end else begin
            rep_l_cnt_d = rep_l_cnt_q + 1'b1;
        end
    end

    always_comb begin
        rep_r_cnt_d = rep_r_cnt_q;
        rep_r_arm_d = rep_r_arm_q;
        rep_r_fire  = 1'b0;
        if (!lvl_r || lvl_l) begin
            rep_r_cnt_d = '0;
            rep_r_arm_d = 1'b0;
        end else if (rep_r_cnt_q == (rep_r_arm_q ? RW'(REPEAT_RATE - 1) : RW'(REPEAT_DELAY - 1))) begin
            rep_r_fire  = 1'b1;
            rep_r_cnt_d = '0;
            rep_r_arm_d = 1'b1;
        end else begin
            rep_r_cnt_d = rep_r_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rep_l_cnt_q <= '0;
            rep_r_cnt_q <= '0;
            rep_l_arm_q <= 1'b0;
            rep_r_arm_q <= 1'b0;
        end else begin
            rep_l_cnt_q <= rep_l_cnt_d;
            rep_r_cnt_q <= rep_r_cnt_d;
            rep_l_arm_q <= rep_l_arm_d;
            rep_r_arm_q <= rep_r_arm_d;
        end
    end

    assign unused_lvl = lvl_d;
`else
    assign rep_l_fire = 1'b0;
    assign rep_r_fire = 1'b0;
    assign unused_lvl = lvl_l ^ lvl_r ^ lvl_d;
`endif

    move_state_e   state_q, state_d;
    move_req_e     move_d;
    logic [GW-1:0] grav_cnt_q, grav_cnt_d;
    logic          grav_pend_q, grav_pend_d;
    logic          down_pend_q, down_pend_d;
    logic          left_pend_q, left_pend_d;
    logic          right_pend_q, right_pend_d;
    logic          drop_q, left_q, right_q, lock_q;

    logic grav_wrap;
    logic lr_cancel;
    logic left_set;
    logic right_set;

    assign grav_wrap = (grav_cnt_q == GW'(GRAVITY_TICKS - 1));
    assign lr_cancel = rise_l & rise_r;
    assign left_set  = rise_l | rep_l_fire;
    assign right_set = rise_r | rep_r_fire;

    // One decision per cycle in RUN; a request taken in the same cycle a new
    // one arrives keeps the new one, except on lock where everything is dropped.
    always_comb begin
        state_d      = state_q;
        move_d       = MV_NONE;
        grav_cnt_d   = grav_cnt_q;
        grav_pend_d  = grav_pend_q;
        down_pend_d  = down_pend_q;
        left_pend_d  = left_pend_q;
        right_pend_d = right_pend_q;

        if (!run) begin
            state_d      = ST_IDLE;
            grav_pend_d  = 1'b0;
            down_pend_d  = 1'b0;
            left_pend_d  = 1'b0;
            right_pend_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d      = ST_RUN;
                    grav_pend_d  = 1'b0;
                    down_pend_d  = 1'b0;
                    left_pend_d  = 1'b0;
                    right_pend_d = 1'b0;
                end

                ST_RUN, ST_SETTLE: begin
                    if (grav_wrap || rise_d) begin
                        grav_cnt_d = '0;
                    end else begin
                        grav_cnt_d = grav_cnt_q + 1'b1;
                    end

                    if (state_q == ST_SETTLE) begin
                        state_d = ST_RUN;
                    end else if (grav_pend_q || down_pend_q) begin
                        grav_pend_d = 1'b0;
                        down_pend_d = 1'b0;
                        if (!blk_down) begin
                            move_d  = MV_DROP;
                            state_d = ST_SETTLE;
                        end else begin
                            move_d  = MV_LOCK;
                            state_d = ST_LOCKED;
                        end
                    end else if (left_pend_q) begin
                        left_pend_d = 1'b0;
                        if (!blk_left) begin
                            move_d  = MV_LEFT;
                            state_d = ST_SETTLE;
                        end
                    end else if (right_pend_q) begin
                        right_pend_d = 1'b0;
                        if (!blk_right) begin
                            move_d  = MV_RIGHT;
                            state_d = ST_SETTLE;
                        end
                    end

                    if (move_d == MV_LOCK) begin
                        grav_cnt_d   = '0;
                        left_pend_d  = 1'b0;
                        right_pend_d = 1'b0;
                    end else begin
                        grav_pend_d = grav_pend_d | grav_wrap;
                        down_pend_d = down_pend_d | rise_d;
                        if (lr_cancel) begin
                            left_pend_d  = 1'b0;
                            right_pend_d = 1'b0;
                        end else begin
                            left_pend_d  = left_pend_d | left_set;
                            right_pend_d = right_pend_d | right_set;
                        end
                    end
                end

                ST_LOCKED: begin
                    grav_cnt_d   = '0;
                    grav_pend_d  = 1'b0;
                    down_pend_d  = 1'b0;
                    left_pend_d  = 1'b0;
                    right_pend_d = 1'b0;
                    if (spawn) begin
                        state_d = ST_RUN;
                    end
                end

                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            grav_cnt_q   <= '0;
            grav_pend_q  <= 1'b0;
            down_pend_q  <= 1'b0;
            left_pend_q  <= 1'b0;
            right_pend_q <= 1'b0;
            drop_q       <= 1'b0;
            left_q       <= 1'b0;
            right_q      <= 1'b0;
            lock_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            grav_cnt_q   <= grav_cnt_d;
            grav_pend_q  <= grav_pend_d;
            down_pend_q  <= down_pend_d;
            left_pend_q  <= left_pend_d;
            right_pend_q <= right_pend_d;
            drop_q       <= (move_d == MV_DROP);
            left_q       <= (move_d == MV_LEFT);
            right_q      <= (move_d == MV_RIGHT);
            lock_q       <= (move_d == MV_LOCK);
        end
    end

    assign drop  = drop_q;
    assign left  = left_q;
    assign right = right_q;
    assign lock  = lock_q;

endmodule

// File: tb/tb_tetris_move_ctrl.sv
// Self-checking bench for tetris_move_ctrl: directed scenarios plus random
// stimulus, all compared against a cycle-level behavioural model of the rules.
module tb_tetris_move_ctrl;

    localparam int GT = 8;
    localparam int RD = 10;
    localparam int RR = 4;

    localparam int P_IDLE   = 0;
    localparam int P_PLAY   = 1;
    localparam int P_SETTLE = 2;
    localparam int P_WAIT   = 3;

    logic clk = 1'b0;
    logic rst_n, run, spawn;
    logic btn_left, btn_right, btn_down;
    logic blk_left, blk_right, blk_down;
    logic drop, left, right, lock;
    logic [3:0] obs;

    int checks = 0;
    int errors = 0;

    int       mode, gcnt, held_l, held_r;
    bit       pg, pd, pl, pr;
    bit [2:0] hl, hr, hd;
    bit [3:0] exp_out;

    assign obs = {drop, left, right, lock};

    always #5 clk = ~clk;

    tetris_move_ctrl #(
        .GRAVITY_TICKS (GT),
        .REPEAT_DELAY  (RD),
        .REPEAT_RATE   (RR)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .run       (run),
        .spawn     (spawn),
        .btn_left  (btn_left),
        .btn_right (btn_right),
        .btn_down  (btn_down),
        .blk_left  (blk_left),
        .blk_right (blk_right),
        .blk_down  (blk_down),
        .drop      (drop),
        .left      (left),
        .right     (right),
        .lock      (lock)
    );

    task automatic model_reset();
        mode = P_IDLE; gcnt = 0; held_l = 0; held_r = 0;
        pg = 0; pd = 0; pl = 0; pr = 0;
        hl = '0; hr = '0; hd = '0;
        exp_out = '0;
    endtask

    // hX[k] holds the button value sampled k+1 edges ago; a press sampled
    // at edge e becomes a request two edges later.
    task automatic model_edge();
        bit rl, rr, rd, fl, fr, wrapped, locked_now;
        exp_out = '0;
        rl = hl[1] && !hl[2];
        rr = hr[1] && !hr[2];
        rd = hd[1] && !hd[2];
        fl = 0;
        fr = 0;
`ifdef TETRIS_AUTOREPEAT_EN
        if (hl[1] && !hr[1]) held_l++; else held_l = 0;
        if (hr[1] && !hl[1]) held_r++; else held_r = 0;
        fl = (held_l == RD) || (held_l > RD && (held_l - RD) % RR == 0);
        fr = (held_r == RD) || (held_r > RD && (held_r - RD) % RR == 0);
`endif
        if (!run) begin
            mode = P_IDLE;
            pg = 0; pd = 0; pl = 0; pr = 0;
        end else if (mode == P_IDLE) begin
            mode = P_PLAY;
            pg = 0; pd = 0; pl = 0; pr = 0;
        end else if (mode == P_WAIT) begin
            gcnt = 0;
            if (spawn) mode = P_PLAY;
        end else begin
            wrapped = (gcnt == GT - 1);
            gcnt = (wrapped || rd) ? 0 : gcnt + 1;
            locked_now = 0;
            if (mode == P_SETTLE) begin
                mode = P_PLAY;
            end else if (pg || pd) begin
                pg = 0; pd = 0;
                if (!blk_down) begin
                    exp_out = 4'b1000; mode = P_SETTLE;
                end else begin
                    exp_out = 4'b0001; mode = P_WAIT; locked_now = 1;
                end
            end else if (pl) begin
                pl = 0;
                if (!blk_left) begin exp_out = 4'b0100; mode = P_SETTLE; end
            end else if (pr) begin
                pr = 0;
                if (!blk_right) begin exp_out = 4'b0010; mode = P_SETTLE; end
            end
            if (locked_now) begin
                pl = 0; pr = 0; gcnt = 0;
            end else begin
                pg |= wrapped;
                pd |= rd;
                if (rl && rr) begin
                    pl = 0; pr = 0;
                end else begin
                    pl |= (rl || fl);
                    pr |= (rr || fr);
                end
            end
        end
        hl = {hl[1:0], btn_left};
        hr = {hr[1:0], btn_right};
        hd = {hd[1:0], btn_down};
    endtask

    task automatic tick();
        @(posedge clk);
        if (!rst_n) model_reset();
        else model_edge();
        @(negedge clk);
    endtask

    task automatic tick_until_drop(input int limit, output bit seen);
        seen = 0;
        for (int i = 0; i < limit && !seen; i++) begin
            tick();
            if (drop === 1'b1) seen = 1;
        end
    endtask

    task automatic test_reset();
        rst_n = 0; run = 0; spawn = 0;
        btn_left = 0; btn_right = 0; btn_down = 0;
        blk_left = 0; blk_right = 0; blk_down = 0;
        repeat (3) tick();
        checks++;
        if (obs !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got %b expected 0000", obs);
        end
        rst_n = 1;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (obs !== exp_out || obs !== 4'b0000) begin
                errors++;
                $display("[TB] FAIL idle_outputs cycle %0d: got %b expected 0000", i, obs);
            end
        end
    endtask

    task automatic test_gravity();
        int last = -1;
        int n_drops = 0;
        run = 1;
        for (int i = 1; i <= 40; i++) begin
            tick();
            checks++;
            if (obs !== exp_out) begin
                errors++;
                $display("[TB] FAIL gravity_model cycle %0d: got %b expected %b", i, obs, exp_out);
            end
            if (drop === 1'b1) begin
                if (last >= 0) begin
                    checks++;
                    if (i - last != GT) begin
                        errors++;
                        $display("[TB] FAIL gravity_period: got %0d cycles expected %0d", i - last, GT);
                    end
                end
                last = i;
                n_drops++;
            end
        end
        checks++;
        if (n_drops != 4) begin
            errors++;
            $display("[TB] FAIL gravity_count: got %0d drops expected 4", n_drops);
        end
    endtask

    task automatic test_left_hold();
        bit seen;
        int first = -1;
        int pulses = 0;
        tick_until_drop(20, seen);
        checks++;
        if (!seen) begin
            errors++;
            $display("[TB] FAIL left_sync_drop: got no drop expected one within 20 cycles");
        end
        btn_left = 1;
        for (int i = 1; i <= 20; i++) begin
            tick();
            checks++;
            if (obs !== exp_out) begin
                errors++;
                $display("[TB] FAIL left_model cycle %0d: got %b expected %b", i, obs, exp_out);
            end
            if (left === 1'b1) begin
                pulses++;
                if (first < 0) first = i;
            end
        end
        btn_left = 0;
        checks++;
        if (first != 4) begin
            errors++;
            $display("[TB] FAIL left_latency: got pulse at cycle %0d expected 4", first);
        end
`ifdef TETRIS_AUTOREPEAT_EN
        checks++;
        if (pulses < 2) begin
            errors++;
            $display("[TB] FAIL left_repeat: got %0d pulses expected at least 2", pulses);
        end
`else
        checks++;
        if (pulses != 1) begin
            errors++;
            $display("[TB] FAIL left_single: got %0d pulses expected 1", pulses);
        end
`endif
        repeat (6) tick();
    endtask

    task automatic test_lock();
        bit seen = 0;
        bit dseen;
        blk_down = 1;
        for (int i = 0; i < 20 && !seen; i++) begin
            tick();
            checks++;
            if (obs !== exp_out) begin
                errors++;
                $display("[TB] FAIL lock_model cycle %0d: got %b expected %b", i, obs, exp_out);
            end
            if (lock === 1'b1) seen = 1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("[TB] FAIL lock_pulse: got no lock expected one within 20 cycles");
        end
        btn_left = 1; btn_down = 1;
        for (int i = 0; i < 16; i++) begin
            if (i == 12) begin btn_left = 0; btn_down = 0; end
            tick();
            checks++;
            if (obs !== 4'b0000 || exp_out !== 4'b0000) begin
                errors++;
                $display("[TB] FAIL locked_quiet cycle %0d: got %b expected 0000", i, obs);
            end
        end
        blk_down = 0; spawn = 1;
        tick();
        spawn = 0;
        checks++;
        if (obs !== exp_out) begin
            errors++;
            $display("[TB] FAIL spawn_model: got %b expected %b", obs, exp_out);
        end
        tick_until_drop(20, dseen);
        checks++;
        if (!dseen) begin
            errors++;
            $display("[TB] FAIL spawn_resume: got no drop expected one within 20 cycles");
        end
    endtask

    task automatic test_down_left();
        bit seen;
        bit [3:0] seq [1:8];
        tick_until_drop(20, seen);
        btn_down = 1; btn_left = 1;
        for (int i = 1; i <= 8; i++) begin
            tick();
            seq[i] = obs;
            checks++;
            if (obs !== exp_out) begin
                errors++;
                $display("[TB] FAIL down_left_model cycle %0d: got %b expected %b", i, obs, exp_out);
            end
        end
        btn_down = 0; btn_left = 0;
        checks++;
        if (seq[4] !== 4'b1000 || seq[5] !== 4'b0000 || seq[6] !== 4'b0100) begin
            errors++;
            $display("[TB] FAIL down_left_order: got %b %b %b expected 1000 0000 0100", seq[4], seq[5], seq[6]);
        end
        repeat (6) tick();
    endtask

    task automatic test_back_to_back();
        bit seen;
        int lr_pulses = 0;
        int r_pulses = 0;
        int drops = 0;
        tick_until_drop(20, seen);
        btn_left = 1; btn_right = 1;
        for (int i = 0; i < 12; i++) begin
            tick();
            checks++;
            if (obs !== exp_out) begin
                errors++;
                $display("[TB] FAIL cancel_model cycle %0d: got %b expected %b", i, obs, exp_out);
            end
            if (left === 1'b1 || right === 1'b1) lr_pulses++;
        end
        btn_left = 0; btn_right = 0;
        repeat (4) tick();
        checks++;
        if (lr_pulses != 0) begin
            errors++;
            $display("[TB] FAIL lr_cancel: got %0d left/right pulses expected 0", lr_pulses);
        end
        blk_right = 1; btn_right = 1;
        for (int i = 0; i < 12; i++) begin
            tick();
            checks++;
            if (obs !== exp_out) begin
                errors++;
                $display("[TB] FAIL blk_right_model cycle %0d: got %b expected %b", i, obs, exp_out);
            end
            if (right === 1'b1) r_pulses++;
            if (drop === 1'b1) drops++;
        end
        btn_right = 0;
        repeat (4) tick();
        blk_right = 0;
        checks++;
        if (r_pulses != 0 || drops < 1) begin
            errors++;
            $display("[TB] FAIL blk_right: got %0d right pulses and %0d drops expected 0 and at least 1", r_pulses, drops);
        end
    endtask

    task automatic test_pause();
        bit seen;
        int first = -1;
        int lefts = 0;
        tick_until_drop(20, seen);
        run = 0; btn_left = 1;
        for (int i = 0; i < 9; i++) begin
            if (i == 6) btn_left = 0;
            tick();
            checks++;
            if (obs !== 4'b0000 || exp_out !== 4'b0000) begin
                errors++;
                $display("[TB] FAIL pause_quiet cycle %0d: got %b expected 0000", i, obs);
            end
        end
        run = 1;
        for (int i = 1; i <= 12; i++) begin
            tick();
            checks++;
            if (obs !== exp_out) begin
                errors++;
                $display("[TB] FAIL resume_model cycle %0d: got %b expected %b", i, obs, exp_out);
            end
            if (drop === 1'b1 && first < 0) first = i;
            if (left === 1'b1) lefts++;
        end
        checks++;
        if (first != 9 || lefts != 0) begin
            errors++;
            $display("[TB] FAIL resume_held_count: got drop at %0d with %0d lefts expected 9 and 0", first, lefts);
        end
    endtask

    task automatic test_random();
        run = 1;
        for (int i = 0; i < 1500; i++) begin
            if (run) begin
                if ($urandom_range(0, 99) == 0) run = 0;
            end else if ($urandom_range(0, 2) == 0) begin
                run = 1;
            end
            spawn = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 9) == 0) blk_left  = ~blk_left;
            if ($urandom_range(0, 9) == 0) blk_right = ~blk_right;
            if ($urandom_range(0, 14) == 0) blk_down = ~blk_down;
            if ($urandom_range(0, 6) == 0) btn_left  = ~btn_left;
            if ($urandom_range(0, 6) == 0) btn_right = ~btn_right;
            if ($urandom_range(0, 8) == 0) btn_down  = ~btn_down;
            tick();
            checks++;
            if (obs !== exp_out) begin
                errors++;
                $display("[TB] FAIL random_model cycle %0d: got %b expected %b", i, obs, exp_out);
            end
            checks++;
            if ($countones(obs) > 1) begin
                errors++;
                $display("[TB] FAIL random_exclusive cycle %0d: got %b expected at most one high", i, obs);
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_gravity();
        test_left_hold();
        test_lock();
        test_down_left();
        test_back_to_back();
        test_pause();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
